sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: commands one master may issue per grant before it must yield.
REQ-002 SHALL have parameter OUTSTANDING, default 4: depth of the read-owner FIFO, i.e. maximum reads in flight.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports mN_read_n, mN_write_n  in  1 each  (N=0,1) master command strobes, active-low.
REQ-006 SHALL have ports mN_address  in  32, mN_writeData  in  16, mN_byteEnable_n  in  2  master command fields.
REQ-007 SHALL have ports mN_waitrequest  out  1, mN_readData  out  16, mN_readdatavalid  out  1  master responses.
REQ-008 SHALL have ports s_read_n, s_write_n  out  1, s_address  out  32, s_writeData  out  16, s_byteEnable_n  out  2  toward the SRAM Avalon slave.
REQ-009 SHALL have ports s_waitrequest  in  1, s_readData  in  16, s_readdatavalid  in  1  from the SRAM slave.
REQ-010 SHALL have port err_orphan  out  1  sticky flag: read data returned with no owner recorded.

Function
REQ-011 Master N SHALL be "requesting" when mN_read_n==0 or mN_write_n==0.
REQ-012 FSM states SHALL be IDLE, GRANT0, GRANT1; a master SHALL be granted only in its GRANT state, the grant being registered (one-cycle arbitration latency from IDLE).
REQ-013 IDLE: if exactly one master requests, next state SHALL be its GRANT; if both request, the master not granted last SHALL win (round-robin).
REQ-014 The non-granted master SHALL see mN_waitrequest=1 whenever it requests; a non-requesting master SHALL see mN_waitrequest=0.
REQ-015 Granted master: s_* command outputs SHALL mirror its inputs combinationally; mN_waitrequest = s_waitrequest OR (read AND owner FIFO full).
REQ-016 When owner FIFO is full and the granted master issues a read, s_read_n SHALL be forced to 1.
REQ-017 With no grant, s_read_n=s_write_n=1 and s_address, s_writeData SHALL be 0, s_byteEnable_n=2'b11.
REQ-018 A command SHALL be accepted in a granted cycle with request asserted and effective waitrequest 0; a 4-bit burst counter SHALL count accepts, cleared on every grant change.
REQ-019 GRANTx SHALL be left when master x stops requesting, or on the accept that brings the count to MAX_BURST; then the other master's GRANT if it is requesting, else IDLE.
REQ-020 Each accepted read SHALL push the granted master's ID into the owner FIFO; each s_readdatavalid SHALL pop it; simultaneous push and pop SHALL both take effect.
REQ-021 s_readData SHALL drive both mN_readData; only the owner at FIFO head SHALL see mN_readdatavalid=1, same cycle as s_readdatavalid (zero added latency).
REQ-022 s_readdatavalid with owner FIFO empty SHALL be dropped and SHALL set err_orphan until reset.
REQ-023 Accepted writes SHALL not touch the owner FIFO.

Reset
REQ-024 On rst: state IDLE, last-granted = master 1 (master 0 wins first tie), burst counter 0, owner FIFO empty, err_orphan 0; outputs per REQ-014/REQ-017.
REQ-025 Reset mid-operation SHALL abandon in-flight reads; their later readdatavalid pulses SHALL set err_orphan.

Configuration
REQ-026 With SRAM_ARB_PRIORITY_EN defined, ties in IDLE SHALL always go to master 0 and GRANT1 SHALL be left after any accept while master 0 requests; without it, round-robin per REQ-013/REQ-019.

Structure
REQ-027 Package sram_arb_pkg SHALL hold the state enum typedef, the master-ID typedef and the MAX_BURST/OUTSTANDING defaults.
REQ-028 The owner FIFO SHALL be sub-module sram_arb_owner_fifo (1-bit wide, depth OUTSTANDING, full/empty outputs).

Verification
REQ-029 m0 reads 0x10 alone: GRANT0 after 1 cycle, s_address=0x10, data 0xBEEF returns only on m0_readdatavalid.
REQ-030 Both request from reset: m0 granted first; after m0 drops, m1 granted next cycle with no IDLE bubble.
REQ-031 m0 holds 12 back-to-back writes, m1 waiting: m0 yields after 8 accepts, m1 granted, m0 resumes afterwards.
REQ-032 Five reads with s_readdatavalid held off: fifth stalls (m0_waitrequest=1, s_read_n=1) until first data pops.
REQ-033 Interleaved reads m0,m1,m0: returns 0x1111,0x2222,0x3333 steer to m0,m1,m0 in order.
REQ-034 s_readdatavalid pulse after rst with no reads: err_orphan=1 and no mN_readdatavalid.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-master SRAM arbiter.
// Optional feature: define SRAM_ARB_PRIORITY_EN for fixed master-0 priority.
package sram_arb_pkg;

    localparam int DEF_MAX_BURST   = 8;
    localparam int DEF_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t MASTER0 = 1'b0;
    localparam master_id_t MASTER1 = 1'b1;

    function automatic arb_state_t grant_state(input master_id_t id);
        return (id == MASTER1) ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/sram_arb_owner_fifo.sv
// Records which master issued each outstanding read so returning data can be steered.
// Pops on an empty FIFO are ignored; the caller flags them as orphans.
module sram_arb_owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = DEF_OUTSTANDING
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  master_id_t i_push_id,
    input  logic       i_pop,
    output master_id_t o_head_id,
    output logic       o_full,
    output logic       o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    master_id_t     r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head_id = r_mem[r_rd_ptr];

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_do_pop)
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master Avalon arbiter in front of one SRAM slave, with burst-limited round-robin
// and read-data steering. Define SRAM_ARB_PRIORITY_EN to give master 0 fixed priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int OUTSTANDING = DEF_OUTSTANDING
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_read_n,
    input  logic        m0_write_n,
    input  logic [31:0] m0_address,
    input  logic [15:0] m0_writeData,
    input  logic [1:0]  m0_byteEnable_n,
    output logic        m0_waitrequest,
    output logic [15:0] m0_readData,
    output logic        m0_readdatavalid,
    input  logic        m1_read_n,
    input  logic        m1_write_n,
    input  logic [31:0] m1_address,
    input  logic [15:0] m1_writeData,
    input  logic [1:0]  m1_byteEnable_n,
    output logic        m1_waitrequest,
    output logic [15:0] m1_readData,
    output logic        m1_readdatavalid,
    output logic        s_read_n,
    output logic        s_write_n,
    output logic [31:0] s_address,
    output logic [15:0] s_writeData,
    output logic [1:0]  s_byteEnable_n,
    input  logic        s_waitrequest,
    input  logic [15:0] s_readData,
    input  logic        s_readdatavalid,
    output logic        err_orphan
);

    arb_state_t  r_state;
    master_id_t  r_last;
    logic [3:0]  r_burst_cnt;
    logic        r_err_orphan;

    logic        w_m0_req;
    logic        w_m1_req;
    logic        w_granted;
    master_id_t  w_sel_id;
    logic        w_sel_read_n;
    logic        w_sel_write_n;
    logic        w_sel_req;
    logic        w_eff_wait;
    logic        w_accept;
    logic        w_push;
    logic [4:0]  w_burst_next;
    logic        w_burst_done;
    logic        w_preempt;
    logic        w_leave;
    logic        w_other_req;
    master_id_t  w_tie_winner;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    master_id_t  w_head_id;

    assign w_m0_req  = !m0_read_n || !m0_write_n;
    assign w_m1_req  = !m1_read_n || !m1_write_n;
    assign w_granted = (r_state != IDLE);
    assign w_sel_id  = (r_state == GRANT1) ? MASTER1 : MASTER0;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_sel_read_n   = 1'b1;
        w_sel_write_n  = 1'b1;
        s_address      = '0;
        s_writeData    = '0;
        s_byteEnable_n = 2'b11;
        case (r_state)
            GRANT0: begin
                w_sel_read_n   = m0_read_n;
                w_sel_write_n  = m0_write_n;
                s_address      = m0_address;
                s_writeData    = m0_writeData;
                s_byteEnable_n = m0_byteEnable_n;
            end
            GRANT1: begin
                w_sel_read_n   = m1_read_n;
                w_sel_write_n  = m1_write_n;
                s_address      = m1_address;
                s_writeData    = m1_writeData;
                s_byteEnable_n = m1_byteEnable_n;
            end
            default: ;
        endcase
    end

    assign w_sel_req  = !w_sel_read_n || !w_sel_write_n;
    assign w_eff_wait = s_waitrequest || (!w_sel_read_n && w_fifo_full);
    assign w_accept   = w_granted && w_sel_req && !w_eff_wait;
    assign w_push     = w_accept && !w_sel_read_n;

    // A read is held off the slave while there is no room to record its owner.
    assign s_read_n  = w_sel_read_n || w_fifo_full;
    assign s_write_n = w_sel_write_n;

    assign m0_waitrequest   = (r_state == GRANT0) ? w_eff_wait : w_m0_req;
    assign m1_waitrequest   = (r_state == GRANT1) ? w_eff_wait : w_m1_req;
    assign m0_readData      = s_readData;
    assign m1_readData      = s_readData;
    assign m0_readdatavalid = s_readdatavalid && !w_fifo_empty && (w_head_id == MASTER0);
    assign m1_readdatavalid = s_readdatavalid && !w_fifo_empty && (w_head_id == MASTER1);
    assign err_orphan       = r_err_orphan;

    assign w_burst_next = {1'b0, r_burst_cnt} + 5'd1;
    assign w_burst_done = w_accept && (w_burst_next == 5'(MAX_BURST));
    assign w_other_req  = (r_state == GRANT0) ? w_m1_req : w_m0_req;

`ifdef SRAM_ARB_PRIORITY_EN
    assign w_preempt    = (r_state == GRANT1) && w_accept && w_m0_req;
    assign w_tie_winner = MASTER0;
`else
    assign w_preempt    = 1'b0;
    assign w_tie_winner = ~r_last;
`endif

    assign w_leave = !w_sel_req || w_burst_done || w_preempt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last       <= MASTER1;
            r_burst_cnt  <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (s_readdatavalid && w_fifo_empty) r_err_orphan <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_burst_cnt <= '0;
                    if (w_m0_req && w_m1_req) begin
                        r_state <= grant_state(w_tie_winner);
                        r_last  <= w_tie_winner;
                    end else if (w_m0_req) begin
                        r_state <= GRANT0;
                        r_last  <= MASTER0;
                    end else if (w_m1_req) begin
                        r_state <= GRANT1;
                        r_last  <= MASTER1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (w_leave) begin
                        r_burst_cnt <= '0;
                        if (w_other_req) begin
                            r_state <= grant_state(~w_sel_id);
                            r_last  <= ~w_sel_id;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_accept) begin
                        r_burst_cnt <= w_burst_next[3:0];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sram_arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_push_id (w_sel_id),
        .i_pop     (s_readdatavalid),
        .o_head_id (w_head_id),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, every cycle compared
// against a transaction-level model (grant owner, burst count, queue of read owners).
module tb_sram_arbiter;

    localparam int MAX_BURST   = 8;
    localparam int OUTSTANDING = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_read_n, m0_write_n, m1_read_n, m1_write_n;
    logic [31:0] m0_address, m1_address;
    logic [15:0] m0_writeData, m1_writeData;
    logic [1:0]  m0_byteEnable_n, m1_byteEnable_n;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readData, m1_readData;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read_n, s_write_n;
    logic [31:0] s_address;
    logic [15:0] s_writeData;
    logic [1:0]  s_byteEnable_n;
    logic        s_waitrequest;
    logic [15:0] s_readData;
    logic        s_readdatavalid;
    logic        err_orphan;

    always #5 clk = ~clk;

    sram_arbiter #(
        .MAX_BURST   (MAX_BURST),
        .OUTSTANDING (OUTSTANDING)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .m0_read_n        (m0_read_n),
        .m0_write_n       (m0_write_n),
        .m0_address       (m0_address),
        .m0_writeData     (m0_writeData),
        .m0_byteEnable_n  (m0_byteEnable_n),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readData      (m0_readData),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read_n        (m1_read_n),
        .m1_write_n       (m1_write_n),
        .m1_address       (m1_address),
        .m1_writeData     (m1_writeData),
        .m1_byteEnable_n  (m1_byteEnable_n),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readData      (m1_readData),
        .m1_readdatavalid (m1_readdatavalid),
        .s_read_n         (s_read_n),
        .s_write_n        (s_write_n),
        .s_address        (s_address),
        .s_writeData      (s_writeData),
        .s_byteEnable_n   (s_byteEnable_n),
        .s_waitrequest    (s_waitrequest),
        .s_readData       (s_readData),
        .s_readdatavalid  (s_readdatavalid),
        .err_orphan       (err_orphan)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        int          gap;   // idle cycles after the previous command before this one starts
    } cmd_t;

    cmd_t mq0[$];
    cmd_t mq1[$];
    int   gap0, gap1;
    bit   drv0, drv1;

    // Reference model state: grant owner (-1 none), last winner, burst count, read owners.
    int   g, last, cnt;
    int   own_q[$];
    bit   orphan;
    bit   e_acc, e_acc_rd;

    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic cmd_t mk(input bit wr, input logic [31:0] addr, input logic [15:0] data, input int gap);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.data = data; c.be = 2'b00; c.gap = gap;
        return c;
    endfunction

    task automatic model_reset();
        g = -1; last = 1; cnt = 0; orphan = 0;
        own_q.delete();
    endtask

    task automatic drive_masters();
        drv0 = (gap0 == 0) && (mq0.size() > 0);
        drv1 = (gap1 == 0) && (mq1.size() > 0);
        m0_read_n = 1'b1; m0_write_n = 1'b1; m0_address = '0; m0_writeData = '0; m0_byteEnable_n = 2'b11;
        m1_read_n = 1'b1; m1_write_n = 1'b1; m1_address = '0; m1_writeData = '0; m1_byteEnable_n = 2'b11;
        if (drv0) begin
            m0_read_n = mq0[0].wr; m0_write_n = !mq0[0].wr;
            m0_address = mq0[0].addr; m0_writeData = mq0[0].data; m0_byteEnable_n = mq0[0].be;
        end
        if (drv1) begin
            m1_read_n = mq1[0].wr; m1_write_n = !mq1[0].wr;
            m1_address = mq1[0].addr; m1_writeData = mq1[0].data; m1_byteEnable_n = mq1[0].be;
        end
    endtask

    // Drive this cycle's master commands, let logic settle, compare every output with the model.
    task automatic settle_check();
        bit          full, sel_rd, sel_wr, req_g, wait_g;
        logic [51:0] e_cmd;
        drive_masters();
        #4;
        full   = (own_q.size() == OUTSTANDING);
        sel_rd = (g == 0) ? drv0 && mq0[0].wr == 1'b0 : (g == 1) ? drv1 && mq1[0].wr == 1'b0 : 1'b0;
        sel_wr = (g == 0) ? drv0 && mq0[0].wr == 1'b1 : (g == 1) ? drv1 && mq1[0].wr == 1'b1 : 1'b0;
        req_g  = sel_rd || sel_wr;
        wait_g = s_waitrequest || (sel_rd && full);
        if (g == 0)      e_cmd = {!(sel_rd && !full), !sel_wr, m0_address, m0_writeData, m0_byteEnable_n};
        else if (g == 1) e_cmd = {!(sel_rd && !full), !sel_wr, m1_address, m1_writeData, m1_byteEnable_n};
        else             e_cmd = {1'b1, 1'b1, 32'h0, 16'h0, 2'b11};
        e_acc    = (g >= 0) && req_g && !wait_g;
        e_acc_rd = e_acc && sel_rd;
        check("s_cmd", 64'({s_read_n, s_write_n, s_address, s_writeData, s_byteEnable_n}), 64'(e_cmd));
        check("m_wait", 64'({m0_waitrequest, m1_waitrequest}),
              64'({(g == 0) ? wait_g : drv0, (g == 1) ? wait_g : drv1}));
        check("m_rdv", 64'({m0_readdatavalid, m1_readdatavalid}),
              64'({s_readdatavalid && own_q.size() > 0 && own_q[0] == 0,
                   s_readdatavalid && own_q.size() > 0 && own_q[0] == 1}));
        check("m_rdata", 64'({m0_readData, m1_readData}), 64'({s_readData, s_readData}));
        check("err_orphan", 64'(err_orphan), 64'(orphan));
    endtask

    // Advance the model and the command sources by one clock, then step the clock.
    task automatic end_cycle();
        bit r0, r1, rg, ro, leave;
        int w;
        if (rst) begin
            model_reset();
        end else begin
            r0 = drv0; r1 = drv1;
            if (s_readdatavalid) begin
                if (own_q.size() > 0) void'(own_q.pop_front());
                else orphan = 1;
            end
            if (e_acc_rd) own_q.push_back(g);
            if (g < 0) begin
`ifdef SRAM_ARB_PRIORITY_EN
                w = r0 ? 0 : (r1 ? 1 : -1);
`else
                if (r0 && r1) w = (last == 1) ? 0 : 1;
                else          w = r0 ? 0 : (r1 ? 1 : -1);
`endif
                if (w >= 0) begin g = w; last = w; cnt = 0; end
            end else begin
                rg = (g == 0) ? r0 : r1;
                ro = (g == 0) ? r1 : r0;
                leave = !rg;
                if (e_acc) begin
                    cnt++;
                    if (cnt == MAX_BURST) leave = 1;
`ifdef SRAM_ARB_PRIORITY_EN
                    if (g == 1 && r0) leave = 1;
`endif
                end
                if (leave) begin
                    cnt = 0;
                    if (ro) begin g = 1 - g; last = g; end
                    else g = -1;
                end
            end
            if (gap0 > 0) gap0--;
            if (gap1 > 0) gap1--;
            if (e_acc && g_prev_is(0)) begin void'(mq0.pop_front()); gap0 = (mq0.size() > 0) ? mq0[0].gap : 0; end
            if (e_acc && g_prev_is(1)) begin void'(mq1.pop_front()); gap1 = (mq1.size() > 0) ? mq1[0].gap : 0; end
        end
        @(posedge clk);
        #1;
    endtask

    // Owner of the accepted command, captured before the grant update.
    int g_acc;
    function automatic bit g_prev_is(input int n);
        return g_acc == n;
    endfunction

    task automatic cycle();
        settle_check();
        g_acc = g;
        end_cycle();
    endtask

    task automatic step_explicit_done();
        g_acc = g;
        end_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mq0.delete(); mq1.delete(); gap0 = 0; gap1 = 0;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readData = '0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_idle(input int n);
        s_readdatavalid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_rdv(input logic [15:0] data, input bit exp0, input bit exp1, input string tag);
        s_readdatavalid = 1'b1; s_readData = data;
        settle_check();
        check(tag, 64'({m0_readdatavalid, m1_readdatavalid, m0_readData}), 64'({exp0, exp1, data}));
        step_explicit_done();
        s_readdatavalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pre, total;
        bit m1_seen;
        rst = 1'b1;
        #1;
        do_reset();

        // Lone read from m0 at 0x10, data 0xBEEF steered back only to m0.
        mq0.push_back(mk(1'b0, 32'h10, 16'h0, 0));
        settle_check();
        check("r29_idle", 64'({m0_waitrequest, s_read_n}), 64'({1'b1, 1'b1}));
        step_explicit_done();
        settle_check();
        check("r29_grant", 64'({s_address, s_read_n, m0_waitrequest}), 64'({32'h10, 1'b0, 1'b0}));
        step_explicit_done();
        run_idle(2);
        pulse_rdv(16'hBEEF, 1'b1, 1'b0, "r29_data");
        run_idle(1);

        // Both request from reset: m0 first, m1 right after m0 drops.
        do_reset();
        mq0.push_back(mk(1'b1, 32'h30, 16'hA0, 0));
        mq0.push_back(mk(1'b1, 32'h31, 16'hA1, 0));
        mq1.push_back(mk(1'b1, 32'h40, 16'hB0, 0));
        cycle();
        settle_check();
        check("r30_m0_first", 64'({s_address, s_write_n}), 64'({32'h30, 1'b0}));
        step_explicit_done();
        cycle();
        cycle();
        settle_check();
        check("r30_m1_next", 64'({s_address, s_write_n, s_writeData}), 64'({32'h40, 1'b0, 16'hB0}));
        step_explicit_done();
        run_idle(2);

        // m0 streams 12 writes while m1 waits with one: m0 yields after MAX_BURST accepts.
        do_reset();
        for (int i = 0; i < 12; i++) mq0.push_back(mk(1'b1, 32'h100 + i, 16'(i), 0));
        mq1.push_back(mk(1'b1, 32'h200, 16'h5555, 0));
        pre = 0; total = 0; m1_seen = 0;
        for (int c = 0; c < 30; c++) begin
            settle_check();
            if (!s_write_n && s_address == 32'h200) m1_seen = 1;
            if (!s_write_n && !s_waitrequest && s_address[31:8] == 24'h1) begin
                total++;
                if (!m1_seen) pre++;
            end
            step_explicit_done();
        end
        check("r31_pre_yield", 64'(pre), 64'(MAX_BURST));
        check("r31_m1_served", 64'(m1_seen), 64'(1));
        check("r31_total", 64'(total), 64'(12));

        // Five reads with no returns: the fifth stalls until the first owner pops.
        do_reset();
        for (int i = 0; i < 5; i++) mq0.push_back(mk(1'b0, 32'h300 + i, 16'h0, 0));
        for (int i = 0; i < 5; i++) cycle();
        for (int i = 0; i < 2; i++) begin
            settle_check();
            check("r32_stall", 64'({m0_waitrequest, s_read_n}), 64'({1'b1, 1'b1}));
            step_explicit_done();
        end
        pulse_rdv(16'hA000, 1'b1, 1'b0, "r32_pop");
        settle_check();
        check("r32_resume", 64'({m0_waitrequest, s_read_n, s_address}), 64'({1'b0, 1'b0, 32'h304}));
        step_explicit_done();
        for (int i = 1; i < 5; i++) pulse_rdv(16'hA000 + 16'(i), 1'b1, 1'b0, "r32_drain");
        check("r32_orphan_clear", 64'(err_orphan), 64'(0));

        // Interleaved owners m0, m1, m0.
        do_reset();
        mq0.push_back(mk(1'b0, 32'h20, 16'h0, 0));
        mq0.push_back(mk(1'b0, 32'h22, 16'h0, 3));
        mq1.push_back(mk(1'b0, 32'h21, 16'h0, 0));
        run_idle(9);
        pulse_rdv(16'h1111, 1'b1, 1'b0, "r33_first");
        pulse_rdv(16'h2222, 1'b0, 1'b1, "r33_second");
        pulse_rdv(16'h3333, 1'b1, 1'b0, "r33_third");

        // Orphan return straight after reset.
        do_reset();
        pulse_rdv(16'h7777, 1'b0, 1'b0, "r34_no_owner");
        settle_check();
        check("r34_orphan", 64'(err_orphan), 64'(1));
        step_explicit_done();

        // Reset with reads in flight: their late returns are orphans.
        do_reset();
        mq0.push_back(mk(1'b0, 32'h50, 16'h0, 0));
        mq0.push_back(mk(1'b0, 32'h51, 16'h0, 0));
        run_idle(3);
        do_reset();
        pulse_rdv(16'h8888, 1'b0, 1'b0, "r25_abandoned");
        settle_check();
        check("r25_orphan", 64'(err_orphan), 64'(1));
        step_explicit_done();

        // Random traffic from both masters with random slave stalls and returns.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            mq0.push_back(mk(1'($urandom_range(0, 1)), $urandom, 16'($urandom), $urandom_range(0, 3)));
            mq1.push_back(mk(1'($urandom_range(0, 1)), $urandom, 16'($urandom), $urandom_range(0, 3)));
            mq0[i].be = 2'($urandom);
            mq1[i].be = 2'($urandom);
        end
        for (int c = 0; c < 6000 && (mq0.size() > 0 || mq1.size() > 0 || own_q.size() > 0); c++) begin
            s_waitrequest   = ($urandom_range(0, 3) == 0);
            s_readdatavalid = (own_q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_readData      = 16'($urandom);
            cycle();
        end
        check("rand_drained", 64'(mq0.size() + mq1.size() + own_q.size()), 64'(0));
        s_waitrequest = 1'b0;
        run_idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
